// File: rtl/uart_pkg.sv
// Shared constants for the word-assembling UART receiver.
// FSM state encodings and byte geometry.
package uart_pkg;
   localparam int BYTE_W    = 8;
   localparam int DATA_BITS = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART receiver.
// Loads a half or full bit period; tick_o is high once the count runs out.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic half_i,
   output logic tick_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= half_i ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/uart_rx_word.sv
// UART receiver packing bytes little-endian into LENGTH-bit words.
// Define UART_PARITY_EN for 8E1 frames with parity checking (8N1 otherwise).
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int LENGTH       = 32,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_in,
   output logic [7:0]        rx_byte,
   output logic              UART_Done,
   output logic [LENGTH-1:0] word_out,
   output logic              word_valid,
   output logic              frame_err,
   output logic              parity_err
);
   localparam int NB = LENGTH / BYTE_W;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;

   logic              sync1_q, rx_s_q;
   logic [2:0]        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [KW-1:0]     byte_cnt_q, byte_cnt_d;
   logic [LENGTH-1:0] word_q, word_d;
   logic [LENGTH-1:0] word_out_q, word_out_d;
   logic [LENGTH-1:0] word_tmp;
   logic [7:0]        rx_byte_q, rx_byte_d;
   logic              done_q, done_d;
   logic              wv_q, wv_d;
   logic              ferr_q, ferr_d;
   logic              tmr_load, tmr_half, tmr_tick;
`ifdef UART_PARITY_EN
   logic              par_bad_q, par_bad_d;
   logic              perr_q, perr_d;
`endif

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .load_i (tmr_load),
      .half_i (tmr_half),
      .tick_o (tmr_tick)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      word_out_d = word_out_q;
      rx_byte_d  = rx_byte_q;
      done_d     = 1'b0;
      wv_d       = 1'b0;
      ferr_d     = 1'b0;
      tmr_load   = 1'b0;
      tmr_half   = 1'b0;
`ifdef UART_PARITY_EN
      par_bad_d  = par_bad_q;
      perr_d     = 1'b0;
`endif
      word_tmp = word_q;
      word_tmp[{byte_cnt_q, 3'b000} +: BYTE_W] = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d  = S_START;
               tmr_load = 1'b1;
               tmr_half = 1'b1;
            end
         end
         S_START: begin
            if (tmr_tick) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  tmr_load  = 1'b1;
                  bit_cnt_d = '0;
               end
            end
         end
         S_DATA: begin
            if (tmr_tick) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               tmr_load  = 1'b1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (tmr_tick) begin
               par_bad_d = rx_s_q ^ (^shift_q);
               tmr_load  = 1'b1;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tmr_tick) begin
               state_d = S_IDLE;
               if (!rx_s_q) begin
                  ferr_d = 1'b1;
               end
`ifdef UART_PARITY_EN
               else if (par_bad_q) begin
                  perr_d = 1'b1;
               end
`endif
               else begin
                  rx_byte_d = shift_q;
                  done_d    = 1'b1;
                  // last slot: publish the word and restart at byte 0
                  if (byte_cnt_q == KW'(NB - 1)) begin
                     word_out_d = word_tmp;
                     wv_d       = 1'b1;
                     byte_cnt_d = '0;
                     word_d     = '0;
                  end else begin
                     word_d     = word_tmp;
                     byte_cnt_d = byte_cnt_q + KW'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         word_out_q <= '0;
         rx_byte_q  <= '0;
         done_q     <= 1'b0;
         wv_q       <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
         par_bad_q  <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         sync1_q    <= rx_in;
         rx_s_q     <= sync1_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         word_out_q <= word_out_d;
         rx_byte_q  <= rx_byte_d;
         done_q     <= done_d;
         wv_q       <= wv_d;
         ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
         par_bad_q  <= par_bad_d;
         perr_q     <= perr_d;
`endif
      end
   end

   assign rx_byte    = rx_byte_q;
   assign UART_Done  = done_q;
   assign word_out   = word_out_q;
   assign word_valid = wv_q;
   assign frame_err  = ferr_q;
`ifdef UART_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: frame table plus glitch, reset and break cases.
// Runs 8E1 frames when UART_PARITY_EN is defined.
module tb_uart_rx_word;
   localparam int CPB = 16;
   localparam int LEN = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           rx_in = 1'b1;
   logic [7:0]     rx_byte;
   logic           UART_Done;
   logic [LEN-1:0] word_out;
   logic           word_valid;
   logic           frame_err;
   logic           parity_err;

   int total = 0;
   int bad   = 0;
   int n_done = 0, n_wv = 0, n_ferr = 0, n_perr = 0, n_wv_alone = 0;

   uart_rx_word #(
      .LENGTH       (LEN),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock      (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .rx_byte    (rx_byte),
      .UART_Done  (UART_Done),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (UART_Done)  n_done++;
      if (word_valid) n_wv++;
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (word_valid && !UART_Done) n_wv_alone++;
   end

   typedef struct {
      logic [7:0]  d;
      logic        stop;
      int          gap;
      int          exp_done;
      int          exp_ferr;
      logic [7:0]  exp_byte;
      int          exp_wv;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic hold_bit(input logic b);
      rx_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic par_flip, input int gap);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_PARITY_EN
      hold_bit((^d) ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      hold_bit(stop);
      rx_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rx_in = 1'b1;
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int d0, f0, w0, p0;

      vecs[0] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C, 0, 32'h0};
      vecs[1] = '{8'h00, 1'b1, 0,  1, 0, 8'h00, 0, 32'h0};
      vecs[2] = '{8'h01, 1'b1, 0,  1, 0, 8'h01, 0, 32'h0};
      vecs[3] = '{8'h20, 1'b1, 0,  1, 0, 8'h20, 1, 32'h2001003C};
      vecs[4] = '{8'hA5, 1'b0, 32, 0, 1, 8'h20, 0, 32'h2001003C};
      vecs[5] = '{8'h55, 1'b1, 0,  1, 0, 8'h55, 0, 32'h2001003C};
      vecs[6] = '{8'hAA, 1'b1, 0,  1, 0, 8'hAA, 0, 32'h2001003C};
      vecs[7] = '{8'h0F, 1'b1, 0,  1, 0, 8'h0F, 0, 32'h2001003C};
      vecs[8] = '{8'hF0, 1'b1, 0,  1, 0, 8'hF0, 1, 32'hF00FAA55};

      // reset and idle line
      @(negedge clk);
      do_reset(5);
      check("rst_rx_byte", 32'(rx_byte), 32'h0);
      check("rst_word_out", word_out, 32'h0);
      check("rst_pulses", 32'({UART_Done, word_valid, frame_err, parity_err}), 32'h0);
      repeat (1000) @(negedge clk);
      check("idle_pulses", 32'(n_done + n_wv + n_ferr + n_perr), 32'h0);

      // short low glitch
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      rx_in = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_done", 32'(n_done), 32'h0);
      check("glitch_ferr", 32'(n_ferr), 32'h0);

      // frame table
      for (int i = 0; i < 9; i++) begin
         d0 = n_done; f0 = n_ferr; w0 = n_wv;
         send_frame(vecs[i].d, vecs[i].stop, 1'b0, vecs[i].gap);
         check($sformatf("v%0d_done", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
         check($sformatf("v%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
         check($sformatf("v%0d_byte", i), 32'(rx_byte), 32'(vecs[i].exp_byte));
         check($sformatf("v%0d_wv", i), 32'(n_wv - w0), 32'(vecs[i].exp_wv));
         check($sformatf("v%0d_word", i), word_out, vecs[i].exp_word);
      end
      check("wv_with_done", 32'(n_wv_alone), 32'h0);

      // reset during data bits of the second byte
      d0 = n_done;
      send_frame(8'h99, 1'b1, 1'b0, 0);
      check("pre_rst_done", 32'(n_done - d0), 32'h1);
      hold_bit(1'b0);
      hold_bit(1'b1);
      hold_bit(1'b1);
      hold_bit(1'b0);
      d0 = n_done; f0 = n_ferr; w0 = n_wv;
      do_reset(3);
      check("mid_rst_byte", 32'(rx_byte), 32'h0);
      check("mid_rst_word", word_out, 32'h0);
      repeat (12 * CPB) @(negedge clk);
      check("mid_rst_quiet", 32'((n_done - d0) + (n_ferr - f0) + (n_wv - w0)), 32'h0);
      send_frame(8'h11, 1'b1, 1'b0, 0);
      send_frame(8'h22, 1'b1, 1'b0, 0);
      send_frame(8'h33, 1'b1, 1'b0, 0);
      send_frame(8'h44, 1'b1, 1'b0, 0);
      check("post_rst_done", 32'(n_done - d0), 32'h4);
      check("post_rst_wv", 32'(n_wv - w0), 32'h1);
      check("post_rst_word", word_out, 32'h44332211);
      check("post_rst_byte", 32'(rx_byte), 32'h44);

`ifdef UART_PARITY_EN
      d0 = n_done; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1, 32);
      check("par_bad_perr", 32'(n_perr - p0), 32'h1);
      check("par_bad_done", 32'(n_done - d0), 32'h0);
      check("par_bad_byte", 32'(rx_byte), 32'h44);
      send_frame(8'h07, 1'b1, 1'b0, 32);
      check("par_ok_perr", 32'(n_perr - p0), 32'h1);
      check("par_ok_done", 32'(n_done - d0), 32'h1);
      check("par_ok_byte", 32'(rx_byte), 32'h07);
`else
      p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0, 32);
      check("nopar_perr", 32'(n_perr - p0), 32'h0);
      check("nopar_byte", 32'(rx_byte), 32'h07);
`endif

      // break: line held low for 400 cycles
      d0 = n_done; f0 = n_ferr;
      rx_in = 1'b0;
      repeat (400) @(negedge clk);
      check("break_ferr", 32'(n_ferr - f0), 32'h2);
      check("break_done", 32'(n_done - d0), 32'h0);
      do_reset(3);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
